t_ff_counter_param: RTL and testbench
=====================================

// Module: t_ff_counter_param
// PURPOSE
//  Parametrised synchronous up/down counter built from WIDTH toggle (T) flip-flop cells.
//  Adds a programmable modulus, parallel load, wrap or saturate mode,
//  a terminal-count strobe and a sticky overflow flag.
//  Serves as the general-purpose count/divide element for the lab timer and sequencer blocks.
// PARAMETERS
//  WIDTH      4   counter width in bits (1..16)
//  MODULUS    16  count range 0..MODULUS-1; legal 2..2**WIDTH
//  SATURATE   0   0 = wrap at ends, 1 = hold at ends
//  RESET_VAL  0   value of Q after reset; must be < MODULUS
// PORTS
//  Clk      in   1      single clock, all state updates on rising edge
//  reset_n  in   1      synchronous, active-low reset
//  en       in   1      count enable
//  up       in   1      1 = count up, 0 = count down
//  load     in   1      parallel load strobe
//  D        in   WIDTH  load value
//  clr_ovf  in   1      clears sticky ovf
//  Q        out  WIDTH  current count
//  tc       out  1      terminal-count strobe (combinational)
//  ovf      out  1      sticky overflow/underflow flag
// BEHAVIOUR
//  - Reset: one clock, synchronous and active-low, named Clk. Reset is sampled only on the
//    rising edge of Clk: Q=RESET_VAL, ovf=0. While reset_n=0, tc=0. Reset overrides all other inputs.
//  - Priority at each rising edge with reset_n=1:
//    1) load=1: Q<=D. If D>=MODULUS, Q<=MODULUS-1. en and up are ignored.
//    2) en=1, up=1: Q<MODULUS-1 gives Q<=Q+1. At Q==MODULUS-1:
//       SATURATE=0 gives Q<=0; SATURATE=1 holds Q. Either case sets ovf.
//    3) en=1, up=0: Q>0 gives Q<=Q-1. At Q==0:
//       SATURATE=0 gives Q<=MODULUS-1; SATURATE=1 holds Q. Either case sets ovf.
//    4) en=0: Q holds.
//  - Latency: Q reflects a load or step one clock after the sampling edge.
//  - tc = reset_n & en & ~load & (up ? Q==MODULUS-1 : Q==0).
//    tc is high during exactly the cycle whose edge performs the wrap or saturation.
//  - ovf: set by any wrap/saturate event. Cleared by clr_ovf=1 at the edge.
//    If set and clear coincide on the same edge, set wins (ovf=1).
//  - Direction change (up toggles while en=1) takes effect on the next edge. No idle cycle.
//  - Q never leaves 0..MODULUS-1, including after an out-of-range load.
//  - Reset mid-count or mid-load returns Q=RESET_VAL next edge. No partial update.
//  - Implementation: compute next count combinationally.
//    Per-bit toggle T[i] = Q[i]^next[i] drives WIDTH t_ff_cell instances.
//    Cells share Clk and reset_n. Cell i resets to RESET_VAL[i].
// STRUCTURE
//  - Sub-module t_ff_cell: 1-bit T flip-flop with enable T, sync active-low reset, RST_VAL param.
//    Instantiated WIDTH times via generate.
//  - Shared package/header (cnt_defs): MODE_WRAP=0, MODE_SAT=1, MAX_WIDTH=16.
//  - Elaboration check: MODULUS range and RESET_VAL<MODULUS. Fatal on violation.
// TESTING (WIDTH=4, MODULUS=10, RESET_VAL=0, Clk period 20 ns)
//  1. Reset: reset_n=0 for 2 edges with en=1, load=1, D=7 -> Q=0, ovf=0, tc=0.
//     Release reset_n: Q stays 0 until the first enabled edge.
//  2. Wrap up: SATURATE=0, en=1, up=1, 12 edges -> Q: 1..9,0,1,2.
//     tc high only in the cycle with Q=9; ovf=1 from the wrap edge onward.
//  3. Saturate down: SATURATE=1, load D=2, then en=1, up=0 for 4 edges -> Q: 2,1,0,0,0.
//     tc high while Q=0; ovf set; clr_ovf pulse with en=0 -> ovf=0.
//  4. Load priority/clamp: en=1, up=1, load=1, D=13 -> Q=9, tc=0 that cycle.
//     Next edge (load=0) -> Q=0 (wrap), ovf=1.
//  5. Set/clear collision: Q=9, en=1, up=1, clr_ovf=1 on the same edge -> Q=0, ovf=1.
//  6. Mid-count reset: count to Q=5, drop reset_n for one edge -> Q=0, ovf=0.
//     Async glitch of reset_n between edges -> no effect on Q.

Source files
------------

// File: rtl/t_ff_counter_param_pkg.sv
// Shared definitions for the T-flip-flop counter family: count modes and width limit.
package cnt_defs;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  localparam int unsigned MAX_WIDTH = 16;

endpackage

// File: rtl/t_ff_counter_param_cell.sv
// One-bit toggle flip-flop: flips when t is high, synchronous active-low reset to RST_VAL.
module t_ff_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!reset_n)
      q <= RST_VAL;
    else if (t)
      q <= ~q;
  end

endmodule

// File: rtl/t_ff_counter_param.sv
// Up/down modulo counter built from WIDTH toggle cells, with load clamp,
// wrap/saturate ends, terminal-count strobe and sticky overflow.
module t_ff_counter_param
  import cnt_defs::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MODULUS   = 16,
  parameter int unsigned SATURATE  = 0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             ovf
);

  generate
    if (WIDTH < 1 || WIDTH > MAX_WIDTH || MODULUS < 2 || MODULUS > (2 ** WIDTH) ||
        RESET_VAL >= MODULUS) begin : g_param_check
      $fatal(1, "t_ff_counter_param: illegal WIDTH/MODULUS/RESET_VAL combination");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] RV   = WIDTH'(RESET_VAL);
  localparam logic             SAT  = (SATURATE == int'(MODE_SAT));

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] t;
  logic             at_end;

  assign at_end = up ? (Q == MAXV) : (Q == '0);
  assign tc     = reset_n & en & ~load & at_end;

  always_comb begin
    nxt = Q;
    if (load) begin
      nxt = (D > MAXV) ? MAXV : D;
    end else if (en) begin
      if (up)
        nxt = (Q == MAXV) ? (SAT ? Q : '0) : Q + ONE;
      else
        nxt = (Q == '0) ? (SAT ? Q : MAXV) : Q - ONE;
    end
  end

  // Each cell toggles exactly the bits that differ between current and next count.
  assign t = Q ^ nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_cell #(.RST_VAL(RV[i])) u_cell (
      .clk     (Clk),
      .reset_n (reset_n),
      .t       (t[i]),
      .q       (Q[i])
    );
  end

  // Set dominates clear when a wrap and clr_ovf share an edge.
  always_ff @(posedge Clk) begin
    if (!reset_n)
      ovf <= 1'b0;
    else if (tc)
      ovf <= 1'b1;
    else if (clr_ovf)
      ovf <= 1'b0;
  end

endmodule

// File: tb/tb_t_ff_counter_param.sv
// Directed bench: wrap-mode and saturate-mode instances (WIDTH=4, MODULUS=10) share stimulus.
module tb_t_ff_counter_param;

  logic       clk = 1'b0;
  logic       reset_n, en, up, load, clr_ovf;
  logic [3:0] d;
  logic [3:0] q_w, q_s;
  logic       tc_w, tc_s, ovf_w, ovf_s;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  t_ff_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VAL(0)) dut_w (
    .Clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load), .D(d),
    .clr_ovf(clr_ovf), .Q(q_w), .tc(tc_w), .ovf(ovf_w)
  );

  t_ff_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .RESET_VAL(0)) dut_s (
    .Clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load), .D(d),
    .clr_ovf(clr_ovf), .Q(q_s), .tc(tc_s), .ovf(ovf_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b1; up = 1'b1; load = 1'b1; d = 4'd7; clr_ovf = 1'b0;
    tick();
    tick();
    checks++; if (q_w !== 4'd0) begin errors++; $display("FAIL reset_q got=%0d exp=0", q_w); end
    checks++; if (ovf_w !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf_w); end
    load = 1'b0; up = 1'b0;
    #1;
    checks++; if (tc_w !== 1'b0) begin errors++; $display("FAIL reset_tc got=%b exp=0", tc_w); end
    reset_n = 1'b1; en = 1'b0;
    tick();
    checks++; if (q_w !== 4'd0) begin errors++; $display("FAIL reset_release_q got=%0d exp=0", q_w); end
    checks++; if (q_s !== 4'd0) begin errors++; $display("FAIL reset_release_qs got=%0d exp=0", q_s); end
  endtask

  task automatic test_wrap_up();
    logic [3:0] exp_q;
    en = 1'b1; up = 1'b1; load = 1'b0; clr_ovf = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      checks++;
      if (tc_w !== (i == 9)) begin
        errors++; $display("FAIL wrap_tc step=%0d got=%b exp=%b", i, tc_w, (i == 9));
      end
      tick();
      exp_q = 4'((i + 1) % 10);
      checks++;
      if (q_w !== exp_q) begin
        errors++; $display("FAIL wrap_q step=%0d got=%0d exp=%0d", i, q_w, exp_q);
      end
      checks++;
      if (ovf_w !== (i >= 9)) begin
        errors++; $display("FAIL wrap_ovf step=%0d got=%b exp=%b", i, ovf_w, (i >= 9));
      end
    end
  endtask

  task automatic test_sat_down();
    logic [3:0] exp_seq [4];
    exp_seq = '{4'd1, 4'd0, 4'd0, 4'd0};
    en = 1'b0; load = 1'b1; d = 4'd2; clr_ovf = 1'b1;
    tick();
    checks++; if (q_s !== 4'd2) begin errors++; $display("FAIL sat_load_q got=%0d exp=2", q_s); end
    checks++; if (ovf_s !== 1'b0) begin errors++; $display("FAIL sat_clr_ovf got=%b exp=0", ovf_s); end
    load = 1'b0; clr_ovf = 1'b0; en = 1'b1; up = 1'b0;
    for (int j = 0; j < 4; j++) begin
      #1;
      checks++;
      if (tc_s !== (j >= 2)) begin
        errors++; $display("FAIL sat_tc step=%0d got=%b exp=%b", j, tc_s, (j >= 2));
      end
      tick();
      checks++;
      if (q_s !== exp_seq[j]) begin
        errors++; $display("FAIL sat_q step=%0d got=%0d exp=%0d", j, q_s, exp_seq[j]);
      end
      checks++;
      if (ovf_s !== (j >= 2)) begin
        errors++; $display("FAIL sat_ovf step=%0d got=%b exp=%b", j, ovf_s, (j >= 2));
      end
    end
    en = 1'b0; clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    checks++; if (ovf_s !== 1'b0) begin errors++; $display("FAIL sat_ovf_clear got=%b exp=0", ovf_s); end
    checks++; if (q_s !== 4'd0) begin errors++; $display("FAIL sat_hold_q got=%0d exp=0", q_s); end
  endtask

  task automatic test_load_clamp();
    en = 1'b0; clr_ovf = 1'b1; load = 1'b0;
    tick();
    en = 1'b1; up = 1'b1; load = 1'b1; d = 4'd13; clr_ovf = 1'b0;
    #1;
    checks++; if (tc_w !== 1'b0) begin errors++; $display("FAIL clamp_tc got=%b exp=0", tc_w); end
    tick();
    checks++; if (q_w !== 4'd9) begin errors++; $display("FAIL clamp_q got=%0d exp=9", q_w); end
    checks++; if (q_s !== 4'd9) begin errors++; $display("FAIL clamp_qs got=%0d exp=9", q_s); end
    checks++; if (ovf_w !== 1'b0) begin errors++; $display("FAIL clamp_ovf got=%b exp=0", ovf_w); end
    load = 1'b0;
    #1;
    checks++; if (tc_w !== 1'b1) begin errors++; $display("FAIL clamp_next_tc got=%b exp=1", tc_w); end
    tick();
    checks++; if (q_w !== 4'd0) begin errors++; $display("FAIL clamp_wrap_q got=%0d exp=0", q_w); end
    checks++; if (ovf_w !== 1'b1) begin errors++; $display("FAIL clamp_wrap_ovf got=%b exp=1", ovf_w); end
    checks++; if (q_s !== 4'd9) begin errors++; $display("FAIL clamp_sat_q got=%0d exp=9", q_s); end
  endtask

  task automatic test_collision();
    en = 1'b0; load = 1'b1; d = 4'd9; clr_ovf = 1'b1;
    tick();
    checks++; if (ovf_w !== 1'b0) begin errors++; $display("FAIL coll_pre_ovf got=%b exp=0", ovf_w); end
    checks++; if (q_w !== 4'd9) begin errors++; $display("FAIL coll_pre_q got=%0d exp=9", q_w); end
    load = 1'b0; en = 1'b1; up = 1'b1; clr_ovf = 1'b1;
    tick();
    checks++; if (q_w !== 4'd0) begin errors++; $display("FAIL coll_q got=%0d exp=0", q_w); end
    checks++; if (ovf_w !== 1'b1) begin errors++; $display("FAIL coll_ovf got=%b exp=1", ovf_w); end
    en = 1'b0;
    tick();
    clr_ovf = 1'b0;
    checks++; if (ovf_w !== 1'b0) begin errors++; $display("FAIL coll_clear got=%b exp=0", ovf_w); end
  endtask

  task automatic test_mid_reset();
    en = 1'b0; load = 1'b1; d = 4'd9;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    checks++; if (q_w !== 4'd5) begin errors++; $display("FAIL mid_q got=%0d exp=5", q_w); end
    checks++; if (ovf_w !== 1'b1) begin errors++; $display("FAIL mid_ovf got=%b exp=1", ovf_w); end
    reset_n = 1'b0;
    tick();
    checks++; if (q_w !== 4'd0) begin errors++; $display("FAIL mid_rst_q got=%0d exp=0", q_w); end
    checks++; if (ovf_w !== 1'b0) begin errors++; $display("FAIL mid_rst_ovf got=%b exp=0", ovf_w); end
    reset_n = 1'b1;
    tick();
    checks++; if (q_w !== 4'd1) begin errors++; $display("FAIL mid_resume_q got=%0d exp=1", q_w); end
    en = 1'b0;
    #2 reset_n = 1'b0;
    #3 reset_n = 1'b1;
    tick();
    checks++; if (q_w !== 4'd1) begin errors++; $display("FAIL glitch_q got=%0d exp=1", q_w); end
  endtask

  task automatic test_direction();
    en = 1'b1; up = 1'b1;
    tick();
    up = 1'b0;
    tick();
    tick();
    checks++; if (q_w !== 4'd0) begin errors++; $display("FAIL dir_q got=%0d exp=0", q_w); end
    #1;
    checks++; if (tc_w !== 1'b1) begin errors++; $display("FAIL dir_tc got=%b exp=1", tc_w); end
    tick();
    en = 1'b0;
    checks++; if (q_w !== 4'd9) begin errors++; $display("FAIL dir_under_q got=%0d exp=9", q_w); end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_load_clamp();
    test_collision();
    test_mid_reset();
    test_direction();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
